hilo_muldiv: RTL and testbench

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_muldiv.sv | 157 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: sequential shift-add multiply and restoring divide,
// one bit per cycle, with direct HI/LO writes while idle.
module hilo_muldiv #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [BIT_WIDTH-1:0] Operand_A,
    input  logic [BIT_WIDTH-1:0] Operand_B,
    input  logic [BIT_WIDTH-1:0] Write_Data,
    input  logic                 hi_we,
    input  logic                 lo_we,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [BIT_WIDTH-1:0] HI,
    output logic [BIT_WIDTH-1:0] LO
);
    localparam int W  = BIT_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;
    logic [W-1:0]  opnd;
    logic          is_mul;
    logic          neg_hi;
    logic          neg_lo;
    logic          dbz;

    function automatic logic [W-1:0] mag(input logic signed [W-1:0] x, input logic sgn);
        return (sgn && x < 0) ? W'(-x) : W'(x);
    endfunction

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    logic         sgn_op;
    logic         a_neg;
    logic         b_neg;
    logic         zero_div;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;
    logic [W:0]   mul_sum;
    logic [W:0]   div_sh;
    logic [W:0]   div_sub;
    logic         div_ge;

    assign sgn_op   = ~op[0];
    assign a_neg    = sgn_op & Operand_A[W-1];
    assign b_neg    = sgn_op & Operand_B[W-1];
    assign zero_div = op[1] & (Operand_B == '0);
    assign mag_a    = mag(Operand_A, sgn_op);
    assign mag_b    = mag(Operand_B, sgn_op);

    // Multiply step: conditionally add the multiplicand into the upper half, shift right.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});

    // Divide step: shift the next dividend bit into the remainder and trial-subtract.
    assign div_sh  = {acc_hi, acc_lo[W-1]};
    assign div_ge  = (div_sh >= {1'b0, opnd});
    assign div_sub = div_sh - {1'b0, opnd};

    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    if (!op[1]) begin
                        acc_hi <= '0;
                        acc_lo <= mag_b;
                        opnd   <= mag_a;
                    end else if (zero_div) begin
                        acc_hi <= Operand_A;
                        acc_lo <= '1;
                        opnd   <= '0;
                    end else begin
                        acc_hi <= '0;
                        acc_lo <= mag_a;
                        opnd   <= mag_b;
                    end
                end
            end
            MUL: begin
                acc_hi <= mul_sum[W:1];
                acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
            end
            DIV: begin
                acc_hi <= div_ge ? div_sub[W-1:0] : div_sh[W-1:0];
                acc_lo <= {acc_lo[W-2:0], div_ge};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            HI          <= '0;
            LO          <= '0;
            is_mul      <= 1'b0;
            neg_hi      <= 1'b0;
            neg_lo      <= 1'b0;
            dbz         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) HI <= Write_Data;
                    if (lo_we) LO <= Write_Data;
                    if (start) begin
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_mul <= ~op[1];
                        dbz    <= zero_div;
                        // Remainder follows the dividend's sign; quotient/product the sign difference.
                        neg_lo <= (a_neg ^ b_neg) & ~zero_div;
                        neg_hi <= op[1] ? (a_neg & ~zero_div) : (a_neg ^ b_neg);
                        if (!op[1])        state <= MUL;
                        else if (zero_div) state <= FINISH;
                        else               state <= DIV;
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) state <= FINISH;
                end
                FINISH: begin
                    if (is_mul) begin
                        {HI, LO} <= neg_2w({acc_hi, acc_lo}, neg_lo);
                    end else begin
                        HI <= neg_w(acc_hi, neg_hi);
                        LO <= neg_w(acc_lo, neg_lo);
                    end
                    done        <= 1'b1;
                    div_by_zero <= dbz;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_hilo_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] Operand_A = '0;
    logic [31:0] Operand_B = '0;
    logic [31:0] Write_Data = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;
    exp_t sb[$];

    hilo_muldiv #(.BIT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .Operand_A(Operand_A), .Operand_B(Operand_B), .Write_Data(Write_Data),
        .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
    // the remainder takes the dividend's sign.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb_, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.dbz = 1'b0;
        e.due = 0;
        case (o)
            2'b00: begin p = 64'(sa * sb_); e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    e.hi = a; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    r = sa / sb_; e.lo = r[31:0];
                    r = sa % sb_; e.hi = r[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_hi", 64'(HI), 64'(e.hi));
                chk("result_lo", 64'(LO), 64'(e.lo));
                chk("result_dbz", 64'(div_by_zero), 64'(e.dbz));
                chk("latency", 64'(ecnt), 64'(e.due));
                chk("busy_after_done", 64'(busy), 64'(0));
            end
        end
    end

    // Called at #1 after a posedge with the DUT idle; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        op = o; Operand_A = a; Operand_B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = model(o, a, b);
        e.due = ecnt + ((o[1] && b == 0) ? 1 : 33);
        sb.push_back(e);
        Operand_A = $urandom; Operand_B = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) chk("done_timeout", 64'(done), 64'(1));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", 64'(HI), 64'(0));
        chk("rst_lo", 64'(LO), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dbz", 64'(div_by_zero), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Direct writes in IDLE
        lo_we = 1'b1; Write_Data = 32'h12345678;
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("mtlo_lo", 64'(LO), 64'h12345678);
        chk("mtlo_hi", 64'(HI), 64'(0));
        chk("mtlo_done", 64'(done), 64'(0));
        hi_we = 1'b1; Write_Data = 32'hCAFEF00D;
        @(posedge clk); #1;
        hi_we = 1'b0;
        chk("mthi_hi", 64'(HI), 64'hCAFEF00D);
        chk("mthi_lo", 64'(LO), 64'h12345678);

        // Directed arithmetic cases
        issue(2'b01, 32'hFFFFFFFF, 32'h00000002); wait_done();
        chk("multu_hi", 64'(HI), 64'h1);
        chk("multu_lo", 64'(LO), 64'hFFFFFFFE);
        issue(2'b00, 32'hFFFFFFFD, 32'h00000007); wait_done();
        chk("mult_neg_lo", 64'(LO), 64'hFFFFFFEB);
        issue(2'b10, 32'hFFFFFFF9, 32'h00000002); wait_done();
        chk("div_neg_lo", 64'(LO), 64'hFFFFFFFD);
        chk("div_neg_hi", 64'(HI), 64'hFFFFFFFF);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF); wait_done();
        chk("div_ovf_lo", 64'(LO), 64'h80000000);
        chk("div_ovf_hi", 64'(HI), 64'h0);
        issue(2'b11, 32'h7, 32'h0); wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("dbz_held", 64'(div_by_zero), 64'(1));
        chk("dbz_hi_hold", 64'(HI), 64'h7);
        chk("dbz_lo_hold", 64'(LO), 64'hFFFFFFFF);
        issue(2'b10, 32'h80000000, 32'h0); wait_done();

        // Second start and hi_we during a MULTU are ignored; busy never drops
        issue(2'b01, 32'h00012345, 32'h00006789);
        begin
            int n = 0;
            while (n < 40) begin
                if (n == 9) begin
                    start = 1'b1; op = 2'b00; Operand_A = 32'hDEAD; Operand_B = 32'hBEEF;
                    hi_we = 1'b1; Write_Data = 32'h55555555;
                end else begin
                    start = 1'b0; hi_we = 1'b0;
                end
                @(negedge clk);
                n++;
                if (done) break;
                chk("busy_hold", 64'(busy), 64'(1));
            end
            start = 1'b0; hi_we = 1'b0;
            if (!done) chk("done_timeout_busy", 64'(done), 64'(1));
            @(posedge clk); #1;
        end

        // Start together with a direct write: write lands now, result overwrites later
        lo_we = 1'b1; Write_Data = 32'hA5A5A5A5;
        issue(2'b01, 32'd6, 32'd7);
        lo_we = 1'b0;
        chk("start_we_lo", 64'(LO), 64'hA5A5A5A5);
        chk("start_we_busy", 64'(busy), 64'(1));
        wait_done();
        chk("start_we_result", 64'(LO), 64'd42);

        // Reset in the middle of a DIVU aborts it; start right after release is taken
        issue(2'b11, 32'hFFFFFFF0, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        chk("abort_hi", 64'(HI), 64'(0));
        chk("abort_lo", 64'(LO), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        rst = 1'b1;
        issue(2'b01, 32'd3, 32'd5); wait_done();
        chk("post_rst_lo", 64'(LO), 64'd15);
        chk("post_rst_hi", 64'(HI), 64'd0);

        // Randomized operations
        for (int i = 0; i < 150; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick());
            wait_done();
        end

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
